// File: rtl/divisor_seq.sv
// rtl/divisor_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional feature: define SIGNED_DIV_EN for two's complement operands.
module divisor_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         startIn,
  input  logic [N-1:0] aIn,
  input  logic [N-1:0] bIn,
  output logic [N-1:0] cOut,
  output logic [N-1:0] mod,
  output logic         busy,
  output logic         done,
  output logic         divZero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvs;

  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic [N-1:0]  rem_nx;
  logic [N-1:0]  quo_nx;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  q_res;
  logic [N-1:0]  r_res;

`ifdef SIGNED_DIV_EN
  logic q_neg;
  logic r_neg;

  // Operand magnitudes feed the unsigned core; final result gets signs restored.
  always_comb begin
    a_mag = aIn[N-1] ? (~aIn + 1'b1) : aIn;
    b_mag = bIn[N-1] ? (~bIn + 1'b1) : bIn;
    q_res = q_neg ? (~quo_nx + 1'b1) : quo_nx;
    r_res = r_neg ? (~rem_nx + 1'b1) : rem_nx;
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    a_mag = aIn;
    b_mag = bIn;
    q_res = quo_nx;
    r_res = rem_nx;
  end
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract, keep or restore.
  always_comb begin
    rem_sh = {rem, quo[N-1]};
    trial  = rem_sh - {1'b0, dvs};
    if (!trial[N]) begin
      rem_nx = trial[N-1:0];
      quo_nx = {quo[N-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[N-1:0];
      quo_nx = {quo[N-2:0], 1'b0};
    end
  end

  // Control FSM with registered outputs; DONE holds the extra cycle before the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cOut    <= '0;
      mod     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == '0) begin
            cOut    <= q_res;
            mod     <= r_res;
            divZero <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; DONE also emits the done pulse.
          done  <= (state == DONE);
          busy  <= 1'b0;
          state <= IDLE;
          if (startIn) begin
            busy <= 1'b1;
            if (bIn == '0) begin
              cOut    <= '1;
              mod     <= aIn;
              divZero <= 1'b1;
              state   <= DONE;
            end else begin
              dvs   <= b_mag;
              quo   <= a_mag;
              rem   <= '0;
              cnt   <= CW'(N - 1);
              state <= CALC;
`ifdef SIGNED_DIV_EN
              q_neg <= aIn[N-1] ^ bIn[N-1];
              r_neg <= aIn[N-1];
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
